// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the parametrised FIFO.
//   state_t        3-bit status state encoding
//   INIT..RDWR     state constants (3'b111 is unused)
//   addr_width()   pointer width derived from the FIFO depth
package fifo_pkg;

  typedef logic [2:0] state_t;

  localparam state_t INIT     = 3'b000;
  localparam state_t NO_OP    = 3'b001;
  localparam state_t WRITE    = 3'b010;
  localparam state_t WR_ERROR = 3'b011;
  localparam state_t READ     = 3'b100;
  localparam state_t RD_ERROR = 3'b101;
  localparam state_t RDWR     = 3'b110;

  // A depth of 1 would give a zero-width pointer; clamp to one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage array for fifo_param.
//   clk      clock, rising edge
//   reset    synchronous active-high; clears only the read data register
//   wr_en    write strobe; wr_data is stored at wr_addr
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data is loaded from rd_addr at the same edge
//   rd_addr  read address
//   rd_data  registered read data, holds when rd_en is low
// Storage has no reset. A read and write to the same address in one cycle
// returns the old contents (read-before-write), which the full-FIFO
// simultaneous read/write case depends on.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with registered status state
// and one-cycle ack/error pulses.
//   clk           clock, rising edge
//   reset         synchronous active-high; discards all entries
//   wr_en, din    write request and data
//   rd_en         read request
//   dout          registered read data, valid with rd_ack
//   data_count    occupancy 0..DEPTH
//   full, empty   decodes of data_count
//   wr_ack/wr_err previous-cycle write accepted / rejected
//   rd_ack/rd_err previous-cycle read accepted / rejected
//   state         status state (see fifo_pkg)
//   almost_full, almost_empty  present only when FIFO_ALMOST_FLAGS_EN is defined
// Build option: `define FIFO_ALMOST_FLAGS_EN to add the almost_* flags.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 8,
  parameter int ADDR_WIDTH      = addr_width(DEPTH),
  parameter int ALMOST_FULL_TH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output state_t                state
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;

  assign full  = (data_count == FULL_COUNT);
  assign empty = (data_count == '0);

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_COUNT = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_COUNT = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);
  assign almost_full  = (data_count >= AF_COUNT);
  assign almost_empty = (data_count <= AE_COUNT);
`endif

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write when a read is accepted alongside it. An empty FIFO never
  // forwards din to dout.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_accept),
    .wr_addr(wr_ptr),
    .wr_data(din),
    .rd_en  (rd_accept),
    .rd_addr(rd_ptr),
    .rd_data(dout)
  );

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

  // Status FSM: the next state reflects this cycle's request outcome and
  // does not depend on the current state, except that the unused 3'b111
  // encoding always recovers to NO_OP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= INIT;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      rd_ack <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_ack <= wr_accept;
      wr_err <= wr_en && !wr_accept;
      rd_ack <= rd_accept;
      rd_err <= rd_en && !rd_accept;
      if (state == 3'b111)             state <= NO_OP;
      else if (wr_accept && rd_accept) state <= RDWR;
      else if (rd_en && !rd_accept)    state <= RD_ERROR;
      else if (wr_accept)              state <= WRITE;
      else if (wr_en)                  state <= WR_ERROR;
      else if (rd_accept)              state <= READ;
      else                             state <= NO_OP;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: table-driven directed test of fifo_param (DEPTH=8,
// DATA_WIDTH=32). Each vector gives one cycle of inputs and the outputs
// expected one edge later. Define FIFO_ALMOST_FLAGS_EN to also check the
// almost_* flags.
module tb_fifo_param;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [2:0]  state;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic        almost_full, almost_empty;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_param #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .din         (din),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full (almost_full),
    .almost_empty(almost_empty),
`endif
    .dout        (dout),
    .data_count  (data_count),
    .full        (full),
    .empty       (empty),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .rd_ack      (rd_ack),
    .rd_err      (rd_err),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_INIT = 3'd0, S_NOOP = 3'd1, S_WR = 3'd2, S_WERR = 3'd3,
                         S_RD = 3'd4, S_RERR = 3'd5, S_RDWR = 3'd6;

  typedef struct {
    bit          rst, wr, rd;
    logic [31:0] din;
    logic [31:0] dout;
    int          cnt;
    bit          wa, we, ra, re;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit wr, bit rd, logic [31:0] d, logic [31:0] q,
                              int cnt, bit wa, bit we, bit ra, bit re, logic [2:0] st);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.din = d; v.dout = q; v.cnt = cnt;
    v.wa = wa; v.we = we; v.ra = ra; v.re = re; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input vec_t v);
    logic [3:0] ecnt;
    bit efull, eempty, ok;
    ecnt   = 4'(v.cnt);
    efull  = (v.cnt == 8);
    eempty = (v.cnt == 0);
    ok = (dout === v.dout) && (data_count === ecnt) && (full === efull) &&
         (empty === eempty) && ({wr_ack, wr_err, rd_ack, rd_err} === {v.wa, v.we, v.ra, v.re}) &&
         (state === v.st);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got dout=%h cnt=%0d full=%b empty=%b wa/we/ra/re=%b%b%b%b st=%0d, want dout=%h cnt=%0d full=%b empty=%b wa/we/ra/re=%b%b%b%b st=%0d",
               name, dout, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err, state,
               v.dout, ecnt, efull, eempty, v.wa, v.we, v.ra, v.re, v.st);
    end else begin
      $display("ok   %s: rst=%b wr=%b rd=%b din=%h -> dout=%h cnt=%0d st=%0d",
               name, v.rst, v.wr, v.rd, v.din, dout, data_count, state);
    end
`ifdef FIFO_ALMOST_FLAGS_EN
    checks++;
    if ({almost_full, almost_empty} !== {v.cnt >= 6, v.cnt <= 2}) begin
      failures++;
      $display("FAIL %s_almost: got af/ae=%b%b want %b%b (cnt %0d)",
               name, almost_full, almost_empty, v.cnt >= 6, v.cnt <= 2, v.cnt);
    end
`endif
  endtask

  task automatic apply(input string name, input vec_t v);
    reset = v.rst; wr_en = v.wr; rd_en = v.rd; din = v.din;
    @(posedge clk);
    #1;
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    check(name, v);
  endtask

  initial begin
    vec_t r;
    // Reset-time read, then fill to 8 and overflow once.
    add(0,0,1,0,0,0, 0,0,0,1, S_RERR);
    for (int i = 1; i <= 8; i++) add(0,1,0,32'(i),0,i, 1,0,0,0, S_WR);
    add(0,1,0,32'hDEAD,0,8, 0,1,0,0, S_WERR);
    // Drain in order, then three more through the wrapped pointers.
    for (int i = 1; i <= 8; i++) add(0,0,1,0,32'(i),8-i, 0,0,1,0, S_RD);
    for (int i = 1; i <= 3; i++) add(0,1,0,32'h100+32'(i),8,i, 1,0,0,0, S_WR);
    for (int i = 1; i <= 3; i++) add(0,0,1,0,32'h100+32'(i),3-i, 0,0,1,0, S_RD);
    // Count 4, five simultaneous read+write cycles, then drain.
    for (int i = 1; i <= 4; i++) add(0,1,0,32'h200+32'(i),32'h103,i, 1,0,0,0, S_WR);
    for (int i = 1; i <= 5; i++) add(0,1,1,32'h204+32'(i),32'h200+32'(i),4, 1,0,1,0, S_RDWR);
    for (int i = 1; i <= 4; i++) add(0,0,1,0,32'h205+32'(i),4-i, 0,0,1,0, S_RD);
    // Full FIFO with both requests: oldest comes out, new one fills the slot.
    for (int i = 1; i <= 8; i++) add(0,1,0,32'h300+32'(i),32'h209,i, 1,0,0,0, S_WR);
    add(0,1,1,32'h309,32'h301,8, 1,0,1,0, S_RDWR);
    for (int i = 1; i <= 8; i++) add(0,0,1,0,32'h301+32'(i),8-i, 0,0,1,0, S_RD);
    // Empty FIFO with both requests: write only, read rejected, no bypass.
    add(0,1,1,32'h401,32'h309,1, 1,0,0,1, S_RERR);
    add(0,0,1,0,32'h401,0, 0,0,1,0, S_RD);
    add(0,0,0,0,32'h401,0, 0,0,0,0, S_NOOP);
    // Fill to 5 for the reset sequence below.
    for (int i = 1; i <= 5; i++) add(0,1,0,32'h500+32'(i),32'h401,i, 1,0,0,0, S_WR);

    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    r = '{rst:1, wr:0, rd:0, din:0, dout:0, cnt:0, wa:0, we:0, ra:0, re:0, st:S_INIT};
    check("reset", r);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset at count 5 with a write pending: reset wins, entries discarded.
    r = '{rst:1, wr:1, rd:0, din:32'hBAD, dout:0, cnt:0, wa:0, we:0, ra:0, re:0, st:S_INIT};
    apply("mid_reset", r);
    r = '{rst:0, wr:0, rd:1, din:0, dout:0, cnt:0, wa:0, we:0, ra:0, re:1, st:S_RERR};
    apply("post_reset_rd", r);
    r = '{rst:0, wr:1, rd:0, din:32'h601, dout:0, cnt:1, wa:1, we:0, ra:0, re:0, st:S_WR};
    apply("post_reset_wr", r);
    r = '{rst:0, wr:0, rd:1, din:0, dout:32'h601, cnt:0, wa:0, we:0, ra:1, re:0, st:S_RD};
    apply("post_reset_rd2", r);
    // dout must hold across idle cycles.
    r = '{rst:0, wr:0, rd:0, din:32'h777, dout:32'h601, cnt:0, wa:0, we:0, ra:0, re:0, st:S_NOOP};
    for (int i = 0; i < 3; i++) apply($sformatf("hold%0d", i), r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO with a registered status state machine and per-cycle ack/error flags.
- Successor to the fixed 8-deep, 32-bit FIFO: width and depth are generic, and a simultaneous read+write state is added.
- Used as the standard buffering element between producer/consumer blocks in one clock domain.

Parameters:
- DATA_WIDTH, 32, data bits per entry.
- DEPTH, 8, number of entries; power of two, 2 to 256.
- ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, do not override.
- ALMOST_FULL_TH, DEPTH-2, almost_full asserts when data_count >= this value.
- ALMOST_EMPTY_TH, 2, almost_empty asserts when data_count <= this value.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data, registered.
- data_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  data_count==DEPTH.
- empty  out  1  data_count==0.
- wr_ack  out  1  previous-cycle write accepted.
- wr_err  out  1  previous-cycle write rejected (full).
- rd_ack  out  1  previous-cycle read accepted; dout valid.
- rd_err  out  1  previous-cycle read rejected (empty).
- state  out  3  current status state.
- almost_full  out  1  only with FIFO_ALMOST_FLAGS_EN.
- almost_empty  out  1  only with FIFO_ALMOST_FLAGS_EN.

Behaviour:
- Reset (sampled at clk edge):
  - wr_ptr=0, rd_ptr=0, data_count=0, dout=0, state=INIT.
  - empty=1, full=0; all ack/err=0; almost_empty=1, almost_full=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all entries, and reset wins over simultaneous wr_en/rd_en.
- Write accepted when wr_en=1 and (not full, or rd_en=1 with a read accepted the same cycle):
  - mem[wr_ptr]<=din, wr_ptr increments modulo DEPTH (natural wrap, ADDR_WIDTH bits).
- Read accepted when rd_en=1 and not empty:
  - dout<=mem[rd_ptr] at the same edge, rd_ptr increments modulo DEPTH.
  - Latency: data visible on dout one cycle after the request cycle, coincident with rd_ack=1.
  - dout holds its last value when no read is accepted.
- Simultaneous wr_en=1, rd_en=1:
  - Neither full nor empty: both accepted, data_count unchanged.
  - Full: both accepted; the read returns the oldest entry, the write fills the freed slot, count stays DEPTH.
  - Empty: write accepted, read rejected (rd_err=1); no bypass of din to dout.
- data_count: +1 on write only, -1 on read only, unchanged otherwise; never exceeds DEPTH or goes below 0.
- full, empty, almost_* are combinational decodes of the registered data_count.
- ack/err: registered, one-cycle pulses per request outcome; wr_ack and wr_err are mutually exclusive, as are rd_ack and rd_err.
- State machine (3-bit), next state taken from the request outcome this cycle:
  - INIT=000: after reset only.
  - NO_OP=001: no request.
  - WRITE=010: write-only accepted.
  - WR_ERROR=011: write-only rejected.
  - READ=100: read-only accepted.
  - RD_ERROR=101: any read rejected, including both asserted while empty.
  - RDWR=110: both accepted.
  - 111 is unreachable; if reached, the next state is NO_OP.
- Any state can go to any other state; transitions depend only on inputs and data_count, not on the previous state.

Optional Feature:
- FIFO_ALMOST_FLAGS_EN defined: almost_full and almost_empty ports exist with the thresholds above.
- Undefined: both ports and ALMOST_* threshold logic are absent. The ALMOST_* parameters remain declared but unused.
- All other behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - state localparams INIT..RDWR and the 3-bit state typedef;
  - a function deriving ADDR_WIDTH.
- One sub-module, fifo_mem: DEPTH x DATA_WIDTH register array with one write port and one registered read port. It has no reset on storage.
- Pointers, count, FSM and flags stay in fifo_param.

Test Plan:
- Reset, then rd_en=1 one cycle -> rd_err=1, state=RD_ERROR, data_count=0, dout=0.
- Write 1..8 (DEPTH=8), then a 9th write 0xDEAD -> full=1, 9th cycle gives wr_err=1, state=WR_ERROR, count=8.
- Read 8 entries -> dout sequence 1..8, each with rd_ack=1, ending empty=1; write 3 more and read them to confirm pointer wrap returns correct data.
- Count=4, wr_en=rd_en=1 for 5 cycles -> state=RDWR, count stays 4, FIFO order preserved.
- Full FIFO, wr_en=rd_en=1 -> dout=oldest entry, count=8, wr_ack=rd_ack=1. Empty FIFO, both asserted -> wr_ack=1, rd_err=1, count=1.
- Reset asserted with count=5 and wr_en=1 -> next cycle count=0, empty=1, state=INIT. With FIFO_ALMOST_FLAGS_EN, fill to 6 -> almost_full=1 at count 6; drain to 2 -> almost_empty=1.
